// File: rtl/req_fifo_dispatcher_if.sv
// Purpose: bundles the FIFO peripheral-bus request/response wires and the metadata valid/ready port.
// Latency: none; wires only.
// Backpressure: bus_request_stall holds a bus access; md_ready holds presented metadata.
interface req_fifo_dispatcher_if;
    // peripheral bus toward the requestor metadata FIFO
    logic        bus_ren;
    logic        bus_wen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_error;
    logic        bus_request_stall;

    // popped metadata toward request processing
    logic        md_valid;
    logic [6:0]  md_data;
    logic        md_ready;

    // dispatcher side: issues bus reads, produces metadata
    modport master (
        output bus_ren,
        output bus_wen,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata,
        input  bus_error,
        input  bus_request_stall,
        output md_valid,
        output md_data,
        input  md_ready
    );

    // peripheral / consumer side
    modport slave (
        input  bus_ren,
        input  bus_wen,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata,
        output bus_error,
        output bus_request_stall,
        input  md_valid,
        input  md_data,
        output md_ready
    );
endinterface

// File: rtl/req_fifo_dispatcher.sv
// Purpose: drains the requestor metadata FIFO over its register bus (pop / overrun check / clear) and forwards metadata.
// Latency: bus_ren one cycle after enable&packet_recv is sampled; md_valid one cycle after an unstalled pop (3-cycle packet period).
// Backpressure: bus stalls hold the access (aborted after STALL_LIMIT stalled cycles); md_ready=0 holds md_valid/md_data in OUT.
module req_fifo_dispatcher #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          STALL_LIMIT = 16
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          enable,
    input  logic                          packet_recv,
    input  logic                          overflow,
    req_fifo_dispatcher_if.master         link,
    output logic [15:0]                   pkt_count,
    output logic                          ovf_seen,
    output logic                          bus_err,
    input  logic                          status_clr
);

    // Register window of the FIFO peripheral.
    localparam logic [31:0] ADDR_OVERRUN = BASE_ADDR + 32'h04;
    localparam logic [31:0] ADDR_REN     = BASE_ADDR + 32'h0C;
    localparam logic [31:0] ADDR_CLEAR   = BASE_ADDR + 32'h10;

    // The counter only has to reach STALL_LIMIT-1: the abort decision is taken
    // on the stalled cycle that would bring it to STALL_LIMIT.
    localparam int              CNT_W    = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_LIMIT - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        POP  = 3'd1,
        OUT  = 3'd2,
        CHK  = 3'd3,
        CLR  = 3'd4
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   stall_cnt;

    // Only the low metadata bits of read data carry meaning for this block.
    logic rdata_unused;
    assign rdata_unused = ^link.bus_rdata[31:7];

    // This manager never writes the peripheral.
    assign link.bus_wen   = 1'b0;
    assign link.bus_wdata = 32'h0;

    // Dispatcher FSM; every bus and metadata output is a register so the
    // request stays glitch-free and constant across stalls.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            stall_cnt     <= '0;
            link.bus_ren  <= 1'b0;
            link.bus_addr <= 32'h0;
            link.md_valid <= 1'b0;
            link.md_data  <= 7'h0;
            pkt_count     <= 16'h0;
            ovf_seen      <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    stall_cnt <= '0;
                    // Overflow recovery outranks draining: popping from an
                    // overrun FIFO would forward data that is about to be discarded.
                    if (enable) begin
                        if (overflow) begin
                            state         <= CHK;
                            link.bus_ren  <= 1'b1;
                            link.bus_addr <= ADDR_OVERRUN;
                        end else if (packet_recv) begin
                            state         <= POP;
                            link.bus_ren  <= 1'b1;
                            link.bus_addr <= ADDR_REN;
                        end
                    end
                end

                OUT: begin
                    // No bus activity while the entry waits for the consumer.
                    if (link.md_ready) begin
                        link.md_valid <= 1'b0;
                        pkt_count     <= pkt_count + 16'd1;
                        state         <= IDLE;
                    end
                end

                POP, CHK, CLR: begin
                    if (link.bus_request_stall) begin
                        // Request is held unchanged; give up after the limit so a
                        // hung peripheral cannot wedge the dispatcher.
                        if (stall_cnt == CNT_LAST) begin
                            stall_cnt     <= '0;
                            link.bus_ren  <= 1'b0;
                            link.bus_addr <= 32'h0;
                            bus_err       <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end else begin
                        // The single unstalled cycle completes the access.
                        stall_cnt <= '0;
                        if (link.bus_error) begin
                            link.bus_ren  <= 1'b0;
                            link.bus_addr <= 32'h0;
                            bus_err       <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            case (state)
                                POP: begin
                                    link.md_data  <= link.bus_rdata[6:0];
                                    link.md_valid <= 1'b1;
                                    link.bus_ren  <= 1'b0;
                                    link.bus_addr <= 32'h0;
                                    state         <= OUT;
                                end
                                CHK: begin
                                    // A cleared overrun bit means the flag was
                                    // spurious; leave the FIFO contents alone.
                                    if (link.bus_rdata[0]) begin
                                        link.bus_addr <= ADDR_CLEAR;
                                        state         <= CLR;
                                    end else begin
                                        link.bus_ren  <= 1'b0;
                                        link.bus_addr <= 32'h0;
                                        state         <= IDLE;
                                    end
                                end
                                default: begin
                                    // CLR: FIFO has discarded its contents.
                                    ovf_seen      <= 1'b1;
                                    link.bus_ren  <= 1'b0;
                                    link.bus_addr <= 32'h0;
                                    state         <= IDLE;
                                end
                            endcase
                        end
                    end
                end

                default: begin
                    state         <= IDLE;
                    stall_cnt     <= '0;
                    link.bus_ren  <= 1'b0;
                    link.bus_addr <= 32'h0;
                    link.md_valid <= 1'b0;
                end
            endcase

            // A software clear wins over any sticky set in the same cycle.
            if (status_clr) begin
                ovf_seen <= 1'b0;
                bus_err  <= 1'b0;
            end
        end
    end

endmodule
